// File: rtl/find_channel_rr.sv
// rtl/find_channel_rr.sv - assigns enabled logic channels to physical correlator slots, priority or round-robin
module find_channel_rr #(
    parameter int LOGIC_CH = 32,
    parameter int IDX_W    = 5,
    parameter int PHY_CH   = 4
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         latch_enable_channel,
    input  logic [LOGIC_CH-1:0]          te_channel_enable,
    input  logic                         start_find,
    input  logic                         rr_mode,
    output logic                         find_channel_done,
    output logic                         busy,
    output logic [LOGIC_CH-1:0]          channel_remain,
    output logic [PHY_CH-1:0]            physical_channel_en,
    output logic [PHY_CH*IDX_W-1:0]      logic_channel_index,
    output logic [PHY_CH*LOGIC_CH-1:0]   logic_channel_mask
);

    localparam int SLOT_W = $clog2(PHY_CH) + 1;
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(PHY_CH);

    typedef enum logic [1:0] {S_IDLE, S_FIND, S_ASSIGN} state_t;

    state_t                       state_q;
    logic [SLOT_W-1:0]            slot_q;
    logic [IDX_W-1:0]             pos_q;
    logic [IDX_W-1:0]             rr_ptr_q;
    logic                         rr_mode_q;
    logic [LOGIC_CH-1:0]          remain_q;
    logic [PHY_CH-1:0]            en_q;
    logic [PHY_CH*IDX_W-1:0]      index_q;
    logic [PHY_CH*LOGIC_CH-1:0]   mask_q;

    logic                         lo_v;
    logic                         hi_v;
    logic [IDX_W-1:0]             lo_pos;
    logic [IDX_W-1:0]             hi_pos;
    logic [IDX_W-1:0]             cand_pos;
    logic                         take;

    // Downward scan so the last hit is the lowest set bit; hi_* restricts to positions >= rr_ptr.
    always_comb begin
        lo_v   = 1'b0;
        lo_pos = '0;
        hi_v   = 1'b0;
        hi_pos = '0;
        for (int i = LOGIC_CH - 1; i >= 0; i--) begin
            if (remain_q[i]) begin
                lo_v   = 1'b1;
                lo_pos = IDX_W'(i);
                if (IDX_W'(i) >= rr_ptr_q) begin
                    hi_v   = 1'b1;
                    hi_pos = IDX_W'(i);
                end
            end
        end
    end

    assign cand_pos          = (rr_mode_q && hi_v) ? hi_pos : lo_pos;
    assign take              = (state_q == S_FIND) && lo_v && (slot_q < SLOT_MAX);
    assign find_channel_done = (state_q == S_FIND) && !take;
    assign busy              = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= S_IDLE;
            slot_q    <= '0;
            pos_q     <= '0;
            rr_ptr_q  <= '0;
            rr_mode_q <= 1'b0;
            remain_q  <= '0;
            en_q      <= '0;
            index_q   <= '0;
            mask_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_find) begin
                        en_q      <= '0;
                        index_q   <= '0;
                        mask_q    <= '0;
                        slot_q    <= '0;
                        rr_mode_q <= rr_mode;
                        state_q   <= S_FIND;
                    end
                end
                S_FIND: begin
                    if (take) begin
                        pos_q   <= cand_pos;
                        state_q <= S_ASSIGN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ASSIGN: begin
                    for (int p = 0; p < PHY_CH; p++) begin
                        if (slot_q == SLOT_W'(p)) begin
                            en_q[p]                          <= 1'b1;
                            index_q[p*IDX_W +: IDX_W]        <= pos_q;
                            mask_q[p*LOGIC_CH +: LOGIC_CH]   <= LOGIC_CH'(1) << pos_q;
                        end
                    end
                    slot_q <= slot_q + SLOT_W'(1);
                    if (rr_mode_q) begin
                        rr_ptr_q <= pos_q + IDX_W'(1);
                    end
                    state_q <= S_FIND;
                end
                default: state_q <= S_IDLE;
            endcase

            // A fresh latch overrides the served-bit clear of the same cycle.
            if (latch_enable_channel) begin
                remain_q <= te_channel_enable;
            end else if (state_q == S_ASSIGN) begin
                remain_q[pos_q] <= 1'b0;
            end
        end
    end

    assign channel_remain      = remain_q;
    assign physical_channel_en = en_q;
    assign logic_channel_index = index_q;
    assign logic_channel_mask  = mask_q;

endmodule

// File: tb/tb_find_channel_rr.sv
// tb/tb_find_channel_rr.sv - directed checks of find_channel_rr at 32x4 and 8x1
module tb_find_channel_rr;

    logic         clk = 1'b0;
    logic         rst_b = 1'b0;

    logic         latch_a = 1'b0, start_a = 1'b0, rr_a = 1'b0;
    logic [31:0]  te_a = '0;
    logic         done_a, busy_a;
    logic [31:0]  remain_a;
    logic [3:0]   en_a;
    logic [19:0]  idx_a;
    logic [127:0] mask_a;

    logic         latch_b = 1'b0, start_b = 1'b0, rr_b = 1'b0;
    logic [7:0]   te_b = '0;
    logic         done_b, busy_b;
    logic [7:0]   remain_b;
    logic [0:0]   en_b;
    logic [2:0]   idx_b;
    logic [7:0]   mask_b;

    int tests_run = 0;
    int fails = 0;

    always #5 clk = ~clk;

    find_channel_rr #(.LOGIC_CH(32), .IDX_W(5), .PHY_CH(4)) dut_a (
        .clk(clk), .rst_b(rst_b), .latch_enable_channel(latch_a), .te_channel_enable(te_a),
        .start_find(start_a), .rr_mode(rr_a), .find_channel_done(done_a), .busy(busy_a),
        .channel_remain(remain_a), .physical_channel_en(en_a), .logic_channel_index(idx_a),
        .logic_channel_mask(mask_a)
    );

    find_channel_rr #(.LOGIC_CH(8), .IDX_W(3), .PHY_CH(1)) dut_b (
        .clk(clk), .rst_b(rst_b), .latch_enable_channel(latch_b), .te_channel_enable(te_b),
        .start_find(start_b), .rr_mode(rr_b), .find_channel_done(done_b), .busy(busy_b),
        .channel_remain(remain_b), .physical_channel_en(en_b), .logic_channel_index(idx_b),
        .logic_channel_mask(mask_b)
    );

    task automatic latch_a_val(input logic [31:0] v);
        @(negedge clk);
        te_a = v;
        latch_a = 1'b1;
        @(negedge clk);
        latch_a = 1'b0;
    endtask

    task automatic latch_b_val(input logic [7:0] v);
        @(negedge clk);
        te_b = v;
        latch_b = 1'b1;
        @(negedge clk);
        latch_b = 1'b0;
    endtask

    // n = 1 is the cycle right after the accepting edge; returns once the DUT is back in IDLE.
    task automatic run_round(input bit sel8, input bit rr, output int n);
        @(negedge clk);
        if (sel8) begin start_b = 1'b1; rr_b = rr; end
        else      begin start_a = 1'b1; rr_a = rr; end
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        n = 1;
        while (!(sel8 ? done_b : done_a) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({en_a, idx_a, remain_a, busy_a, done_a} !== '0) begin
            fails++;
            $display("FAIL reset_a_outputs got en=%h idx=%h remain=%h busy=%b done=%b want all 0",
                     en_a, idx_a, remain_a, busy_a, done_a);
        end
        tests_run++;
        if (mask_a !== '0) begin
            fails++;
            $display("FAIL reset_a_mask got %h want 0", mask_a);
        end
        tests_run++;
        if ({en_b, idx_b, mask_b, remain_b, busy_b, done_b} !== '0) begin
            fails++;
            $display("FAIL reset_b_outputs got en=%b idx=%h mask=%h remain=%h want all 0",
                     en_b, idx_b, mask_b, remain_b);
        end
        rst_b = 1'b1;
    endtask

    task automatic test_priority;
        int n;
        latch_a_val(32'h0000_F0F1);
        run_round(1'b0, 1'b0, n);
        tests_run++;
        if (n !== 9) begin fails++; $display("FAIL prio_latency got %0d want 9", n); end
        tests_run++;
        if (en_a !== 4'hF) begin fails++; $display("FAIL prio_en got %h want f", en_a); end
        tests_run++;
        if (idx_a !== {5'd6, 5'd5, 5'd4, 5'd0}) begin
            fails++; $display("FAIL prio_index got %h want %h", idx_a, {5'd6, 5'd5, 5'd4, 5'd0});
        end
        tests_run++;
        if (mask_a !== {32'h40, 32'h20, 32'h10, 32'h1}) begin
            fails++; $display("FAIL prio_mask got %h", mask_a);
        end
        tests_run++;
        if (remain_a !== 32'h0000_F080) begin
            fails++; $display("FAIL prio_remain got %h want 0000f080", remain_a);
        end
        tests_run++;
        if (busy_a !== 1'b0) begin fails++; $display("FAIL prio_idle_busy got %b want 0", busy_a); end
    endtask

    task automatic test_sparse;
        int n;
        latch_a_val(32'h8000_0002);
        run_round(1'b0, 1'b0, n);
        tests_run++;
        if (n !== 5) begin fails++; $display("FAIL sparse_latency got %0d want 5", n); end
        tests_run++;
        if (en_a !== 4'b0011) begin fails++; $display("FAIL sparse_en got %b want 0011", en_a); end
        tests_run++;
        if (idx_a !== {5'd0, 5'd0, 5'd31, 5'd1}) begin
            fails++; $display("FAIL sparse_index got %h want %h", idx_a, {5'd0, 5'd0, 5'd31, 5'd1});
        end
        tests_run++;
        if (mask_a !== {32'h0, 32'h0, 32'h8000_0000, 32'h2}) begin
            fails++; $display("FAIL sparse_mask got %h", mask_a);
        end
        tests_run++;
        if (remain_a !== 32'h0) begin fails++; $display("FAIL sparse_remain got %h want 0", remain_a); end
        run_round(1'b0, 1'b0, n);
        tests_run++;
        if (n !== 1) begin fails++; $display("FAIL empty_latency got %0d want 1", n); end
        tests_run++;
        if ({en_a, idx_a} !== '0 || mask_a !== '0) begin
            fails++; $display("FAIL empty_outputs got en=%b idx=%h want 0", en_a, idx_a);
        end
    endtask

    task automatic test_rr_wrap;
        int n;
        logic [19:0]  exp_idx;
        logic [127:0] exp_mask;
        latch_a_val(32'hFFFF_FFFF);
        for (int r = 0; r < 4; r++) begin
            run_round(1'b0, 1'b1, n);
            for (int p = 0; p < 4; p++) begin
                exp_idx[p*5 +: 5]    = 5'(4*r + p);
                exp_mask[p*32 +: 32] = 32'h1 << (4*r + p);
            end
            tests_run++;
            if (n !== 9 || en_a !== 4'hF) begin
                fails++; $display("FAIL rr_round%0d_lat_en got n=%0d en=%h want 9 f", r, n, en_a);
            end
            tests_run++;
            if (idx_a !== exp_idx || mask_a !== exp_mask) begin
                fails++; $display("FAIL rr_round%0d_slots got idx=%h want %h", r, idx_a, exp_idx);
            end
        end
        tests_run++;
        if (remain_a !== 32'hFFFF_0000) begin
            fails++; $display("FAIL rr_remain got %h want ffff0000", remain_a);
        end
        latch_a_val(32'h0000_0003);
        run_round(1'b0, 1'b1, n);
        tests_run++;
        if (n !== 5 || en_a !== 4'b0011) begin
            fails++; $display("FAIL rr_wrap_lat_en got n=%0d en=%b want 5 0011", n, en_a);
        end
        tests_run++;
        if (idx_a !== {5'd0, 5'd0, 5'd1, 5'd0} || mask_a !== {32'h0, 32'h0, 32'h2, 32'h1}) begin
            fails++; $display("FAIL rr_wrap_slots got idx=%h want 00020", idx_a);
        end
    endtask

    task automatic test_collision;
        int n;
        latch_a_val(32'h0000_0007);
        @(negedge clk);
        start_a = 1'b1;
        rr_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;                    // n = 1
        @(negedge clk);
        start_a = 1'b1;                    // n = 2, sampled while busy
        @(negedge clk);
        start_a = 1'b0;                    // n = 3
        repeat (3) @(negedge clk);         // n = 6, ASSIGN of pos 2
        te_a = 32'h0000_0104;
        latch_a = 1'b1;
        @(negedge clk);                    // n = 7
        latch_a = 1'b0;
        n = 7;
        tests_run++;
        if (remain_a !== 32'h0000_0104) begin
            fails++; $display("FAIL collision_remain got %h want 00000104", remain_a);
        end
        while (!done_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n !== 9) begin fails++; $display("FAIL collision_latency got %0d want 9", n); end
        tests_run++;
        if (en_a !== 4'hF || idx_a !== {5'd2, 5'd2, 5'd1, 5'd0}) begin
            fails++; $display("FAIL collision_slots got en=%h idx=%h want f %h", en_a, idx_a,
                              {5'd2, 5'd2, 5'd1, 5'd0});
        end
        tests_run++;
        if (mask_a !== {32'h4, 32'h4, 32'h2, 32'h1} || remain_a !== 32'h0000_0100) begin
            fails++; $display("FAIL collision_mask_remain got remain=%h want 00000100", remain_a);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n;
        int seen_done;
        latch_a_val(32'h0000_000F);
        @(negedge clk);
        start_a = 1'b1;
        rr_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;                    // n = 1
        repeat (4) @(negedge clk);         // n = 5, FIND after two assignments
        tests_run++;
        if (en_a !== 4'b0011 || busy_a !== 1'b1) begin
            fails++; $display("FAIL midreset_pre got en=%b busy=%b want 0011 1", en_a, busy_a);
        end
        rst_b = 1'b0;
        #1;
        tests_run++;
        if ({en_a, idx_a, remain_a, busy_a, done_a} !== '0 || mask_a !== '0) begin
            fails++; $display("FAIL midreset_outputs got en=%b idx=%h remain=%h busy=%b done=%b want 0",
                              en_a, idx_a, remain_a, busy_a, done_a);
        end
        seen_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_a) seen_done++;
        end
        rst_b = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done_a) seen_done++;
        end
        tests_run++;
        if (seen_done !== 0) begin fails++; $display("FAIL midreset_no_done got %0d pulses want 0", seen_done); end
        run_round(1'b0, 1'b0, n);
        tests_run++;
        if (n !== 1 || en_a !== 4'b0) begin
            fails++; $display("FAIL midreset_restart got n=%0d en=%b want 1 0", n, en_a);
        end
    endtask

    task automatic test_param_sweep;
        int n;
        logic [2:0] exp_pos [4];
        exp_pos = '{3'd0, 3'd2, 3'd5, 3'd7};
        latch_b_val(8'hA5);
        for (int r = 0; r < 4; r++) begin
            run_round(1'b1, 1'b1, n);
            tests_run++;
            if (n !== 3 || en_b !== 1'b1 || idx_b !== exp_pos[r] || mask_b !== (8'h1 << exp_pos[r])) begin
                fails++; $display("FAIL sweep_round%0d got n=%0d idx=%0d mask=%h want 3 %0d", r, n, idx_b,
                                  mask_b, exp_pos[r]);
            end
        end
        tests_run++;
        if (remain_b !== 8'h0) begin fails++; $display("FAIL sweep_remain got %h want 0", remain_b); end
        latch_b_val(8'hA5);
        run_round(1'b1, 1'b1, n);
        tests_run++;
        if (n !== 3 || idx_b !== 3'd0 || remain_b !== 8'hA4) begin
            fails++; $display("FAIL sweep_round5 got n=%0d idx=%0d remain=%h want 3 0 a4", n, idx_b, remain_b);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_sparse();
        test_rr_wrap();
        test_collision();
        test_reset_mid();
        test_param_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
